// File: rtl/ysyx_040750_ex_mem_reg_if.sv
// EX/MEM boundary bundle: EX-side offer, MEM-side head view, forwarding view and stall counter.
// The register block takes the slave side; the EX/MEM environment takes the master side.
interface ysyx_040750_ex_mem_reg_if #(
    parameter int CTRL_W = 16,
    parameter int RD_W   = 5
);
    logic              I_flush;
    logic              I_ex_valid;
    logic              I_ex_result_valid;
    logic [63:0]       I_ex_result;
    logic [63:0]       I_ex_store_data;
    logic [63:0]       I_ex_pc;
    logic [RD_W-1:0]   I_ex_rd;
    logic              I_ex_rd_wen;
    logic [CTRL_W-1:0] I_ex_ctrl;
    logic              O_ex_ready;
    logic              O_mem_valid;
    logic              I_mem_ready;
    logic [63:0]       O_mem_result;
    logic [63:0]       O_mem_store_data;
    logic [63:0]       O_mem_pc;
    logic [RD_W-1:0]   O_mem_rd;
    logic              O_mem_rd_wen;
    logic [CTRL_W-1:0] O_mem_ctrl;
    logic              O_fwd_valid;
    logic [RD_W-1:0]   O_fwd_rd;
    logic [63:0]       O_fwd_data;
    logic [31:0]       O_stall_cnt;

    modport slave (
        input  I_flush, I_ex_valid, I_ex_result_valid, I_ex_result, I_ex_store_data,
               I_ex_pc, I_ex_rd, I_ex_rd_wen, I_ex_ctrl, I_mem_ready,
        output O_ex_ready, O_mem_valid, O_mem_result, O_mem_store_data, O_mem_pc,
               O_mem_rd, O_mem_rd_wen, O_mem_ctrl, O_fwd_valid, O_fwd_rd, O_fwd_data,
               O_stall_cnt
    );

    modport master (
        output I_flush, I_ex_valid, I_ex_result_valid, I_ex_result, I_ex_store_data,
               I_ex_pc, I_ex_rd, I_ex_rd_wen, I_ex_ctrl, I_mem_ready,
        input  O_ex_ready, O_mem_valid, O_mem_result, O_mem_store_data, O_mem_pc,
               O_mem_rd, O_mem_rd_wen, O_mem_ctrl, O_fwd_valid, O_fwd_rd, O_fwd_data,
               O_stall_cnt
    );
endinterface

// File: rtl/ysyx_040750_ex_mem_reg.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (head H, skid S).
// EX ready comes straight from a flop, so MEM backpressure never reaches the ALU combinationally.
module ysyx_040750_ex_mem_reg #(
    parameter int CTRL_W = 16,
    parameter int RD_W   = 5
) (
    input logic                      I_sys_clk,
    input logic                      I_rst,
    ysyx_040750_ex_mem_reg_if.slave  bus
);
    typedef struct packed {
        logic [63:0]       result;
        logic [63:0]       store_data;
        logic [63:0]       pc;
        logic [RD_W-1:0]   rd;
        logic              rd_wen;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    ent_t        h_q, h_d, s_q, s_d, in_ent;
    logic        h_vld_q, h_vld_d, s_vld_q, s_vld_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        acc, drn, stall;

    always_comb begin
        in_ent.result     = bus.I_ex_result;
        in_ent.store_data = bus.I_ex_store_data;
        in_ent.pc         = bus.I_ex_pc;
        in_ent.rd         = bus.I_ex_rd;
        in_ent.rd_wen     = bus.I_ex_rd_wen;
        in_ent.ctrl       = bus.I_ex_ctrl;
    end

    assign acc   = bus.I_ex_valid & bus.I_ex_result_valid & ~s_vld_q;
    assign drn   = h_vld_q & bus.I_mem_ready;
    assign stall = bus.I_ex_valid & bus.I_ex_result_valid & s_vld_q;

    always_comb begin
        h_d         = h_q;
        s_d         = s_q;
        h_vld_d     = h_vld_q;
        s_vld_d     = s_vld_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        // Flush only kills the valid bits; stale payload is harmless behind them.
        if (bus.I_flush) begin
            h_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!h_vld_q) begin
            if (acc) begin
                h_d     = in_ent;
                h_vld_d = 1'b1;
            end
        end else if (!s_vld_q) begin
            if (acc && drn) begin
                h_d = in_ent;
            end else if (acc) begin
                s_d     = in_ent;
                s_vld_d = 1'b1;
            end else if (drn) begin
                h_vld_d = 1'b0;
            end
        end else if (drn) begin
            h_d     = s_q;
            s_vld_d = 1'b0;
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            h_q         <= '0;
            s_q         <= '0;
            h_vld_q     <= 1'b0;
            s_vld_q     <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            h_q         <= h_d;
            s_q         <= s_d;
            h_vld_q     <= h_vld_d;
            s_vld_q     <= s_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.O_ex_ready       = ~s_vld_q;
    assign bus.O_mem_valid      = h_vld_q;
    assign bus.O_mem_result     = h_q.result;
    assign bus.O_mem_store_data = h_q.store_data;
    assign bus.O_mem_pc         = h_q.pc;
    assign bus.O_mem_rd         = h_q.rd;
    assign bus.O_mem_rd_wen     = h_q.rd_wen;
    assign bus.O_mem_ctrl       = h_q.ctrl;
    assign bus.O_fwd_valid      = h_vld_q & h_q.rd_wen & (h_q.rd != '0);
    assign bus.O_fwd_rd         = h_q.rd;
    assign bus.O_fwd_data       = h_q.result;
    assign bus.O_stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_ysyx_040750_ex_mem_reg.sv
// Directed bench for the EX/MEM skid register: a FIFO-of-two reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_ysyx_040750_ex_mem_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_040750_ex_mem_reg_if #(.CTRL_W(16), .RD_W(5)) bus ();
    ysyx_040750_ex_mem_reg #(.CTRL_W(16), .RD_W(5)) dut (
        .I_sys_clk(clk),
        .I_rst    (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [63:0] res, sd, pc;
        logic [4:0]  rd;
        logic        wen;
        logic [15:0] ctrl;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mcnt;
    logic        poke = 1'b0;
    logic [31:0] poke_val = '0;
    logic        chk_en = 1'b0;
    logic [63:0] got[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: an ordered list of at most two entries, ready whenever it is not full.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcnt = 32'd0;
        end else begin
            automatic ent_t e;
            automatic bit rdy = (mq.size() < 2);
            automatic bit a   = bus.I_ex_valid && bus.I_ex_result_valid && rdy;
            automatic bit d   = (mq.size() > 0) && bus.I_mem_ready;
            if (poke) mcnt = poke_val;
            else if (bus.I_ex_valid && bus.I_ex_result_valid && !rdy && mcnt != 32'hFFFF_FFFF)
                mcnt = mcnt + 1;
            e.res = bus.I_ex_result; e.sd = bus.I_ex_store_data; e.pc = bus.I_ex_pc;
            e.rd = bus.I_ex_rd; e.wen = bus.I_ex_rd_wen; e.ctrl = bus.I_ex_ctrl;
            if (bus.I_flush) mq.delete();
            else begin
                if (d) void'(mq.pop_front());
                if (a) mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_ready", 64'(bus.O_ex_ready), 64'(mq.size() < 2));
            chk("mem_valid", 64'(bus.O_mem_valid), 64'(mq.size() > 0));
            chk("stall_cnt", 64'(bus.O_stall_cnt), 64'(mcnt));
            if (mq.size() > 0) begin
                chk("mem_result", bus.O_mem_result, mq[0].res);
                chk("mem_store_data", bus.O_mem_store_data, mq[0].sd);
                chk("mem_pc", bus.O_mem_pc, mq[0].pc);
                chk("mem_rd", 64'(bus.O_mem_rd), 64'(mq[0].rd));
                chk("mem_rd_wen", 64'(bus.O_mem_rd_wen), 64'(mq[0].wen));
                chk("mem_ctrl", 64'(bus.O_mem_ctrl), 64'(mq[0].ctrl));
                chk("fwd_valid", 64'(bus.O_fwd_valid), 64'(mq[0].wen && mq[0].rd != 0));
                chk("fwd_rd", 64'(bus.O_fwd_rd), 64'(mq[0].rd));
                chk("fwd_data", bus.O_fwd_data, mq[0].res);
            end else begin
                chk("fwd_valid_empty", 64'(bus.O_fwd_valid), 64'd0);
            end
        end
    end

    // Inputs change at negedge+2; the drain seen by the upcoming posedge is logged first.
    task automatic step();
        if (!bus.I_flush && bus.O_mem_valid === 1'b1 && bus.I_mem_ready)
            got.push_back(bus.O_mem_result);
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic offer(input logic v, input logic rv, input logic [63:0] r, input logic [4:0] rd);
        bus.I_ex_valid        = v;
        bus.I_ex_result_valid = rv;
        bus.I_ex_result       = r;
        bus.I_ex_store_data   = ~r;
        bus.I_ex_pc           = r << 2;
        bus.I_ex_rd           = rd;
        bus.I_ex_rd_wen       = 1'b1;
        bus.I_ex_ctrl         = r[15:0] ^ 16'h5A5A;
    endtask

    task automatic chk_got(input string name, input logic [63:0] exp[$]);
        chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
    endtask

    initial begin
        bus.I_flush = 1'b0;
        bus.I_mem_ready = 1'b1;
        offer(1'b0, 1'b0, 64'd0, 5'd0);

        // Reset, then a single op
        rst = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("rst_ex_ready", 64'(bus.O_ex_ready), 64'd1);
        chk("rst_mem_valid", 64'(bus.O_mem_valid), 64'd0);
        chk("rst_stall_cnt", 64'(bus.O_stall_cnt), 64'd0);
        chk("rst_mem_result", bus.O_mem_result, 64'd0);
        rst = 1'b0;
        offer(1'b1, 1'b1, 64'h1234, 5'd5);
        step();
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        chk("op_mem_valid", 64'(bus.O_mem_valid), 64'd1);
        chk("op_mem_result", bus.O_mem_result, 64'h1234);
        chk("op_fwd_valid", 64'(bus.O_fwd_valid), 64'd1);
        chk("op_fwd_rd", 64'(bus.O_fwd_rd), 64'd5);
        step();

        // Backpressure into the skid slot
        got.delete();
        bus.I_mem_ready = 1'b0;
        offer(1'b1, 1'b1, 64'hA, 5'd1); step();
        offer(1'b1, 1'b1, 64'hB, 5'd2); step();
        chk("skid_ex_ready", 64'(bus.O_ex_ready), 64'd0);
        chk("skid_head", bus.O_mem_result, 64'hA);
        offer(1'b1, 1'b1, 64'hC, 5'd3);
        step(); step(); step();
        chk("skid_stall_cnt", 64'(bus.O_stall_cnt), 64'd3);
        bus.I_mem_ready = 1'b1;
        step(); step();
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        step(); step();
        chk("skid_stall_final", 64'(bus.O_stall_cnt), 64'd4);
        chk_got("skid_order", '{64'hA, 64'hB, 64'hC});

        // Full throughput
        got.delete();
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 1'b1, 64'(i), 5'(i + 1));
            step();
            chk("tp_mem_valid", 64'(bus.O_mem_valid), 64'd1);
            chk("tp_ex_ready", 64'(bus.O_ex_ready), 64'd1);
            chk("tp_head", bus.O_mem_result, 64'(i));
        end
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        step();
        chk_got("tp_order", '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7});

        // Multicycle result, from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        got.delete();
        for (int i = 0; i < 33; i++) begin
            offer(1'b1, 1'b0, 64'hDEAD, 5'd7);
            step();
        end
        chk("mc_wait_valid", 64'(bus.O_mem_valid), 64'd0);
        offer(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7);
        step();
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        chk("mc_head", bus.O_mem_result, 64'hFFFF_FFFF_FFFF_FFFE);
        step(); step();
        chk_got("mc_once", '{64'hFFFF_FFFF_FFFF_FFFE});
        chk("mc_stall_cnt", 64'(bus.O_stall_cnt), 64'd0);

        // Flush from the full state together with a drain and an offer
        bus.I_mem_ready = 1'b0;
        offer(1'b1, 1'b1, 64'h11, 5'd1); step();
        offer(1'b1, 1'b1, 64'h22, 5'd2); step();
        chk("fl_full", 64'(bus.O_ex_ready), 64'd0);
        bus.I_flush = 1'b1;
        bus.I_mem_ready = 1'b1;
        offer(1'b1, 1'b1, 64'h33, 5'd3);
        step();
        bus.I_flush = 1'b0;
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        chk("fl_mem_valid", 64'(bus.O_mem_valid), 64'd0);
        chk("fl_ex_ready", 64'(bus.O_ex_ready), 64'd1);
        got.delete();
        bus.I_mem_ready = 1'b0;
        offer(1'b1, 1'b1, 64'h55, 5'd4); step();
        offer(1'b0, 1'b0, 64'd0, 5'd0); step();
        chk("fl_head", bus.O_mem_result, 64'h55);
        chk("fl_alone", 64'(bus.O_ex_ready), 64'd1);
        bus.I_mem_ready = 1'b1;
        step();
        chk_got("fl_drain", '{64'h55});

        // rd=0 suppresses forwarding; then saturate the stall counter
        bus.I_mem_ready = 1'b0;
        offer(1'b1, 1'b1, 64'h77, 5'd0); step();
        chk("rd0_mem_valid", 64'(bus.O_mem_valid), 64'd1);
        chk("rd0_fwd_valid", 64'(bus.O_fwd_valid), 64'd0);
        offer(1'b1, 1'b1, 64'h88, 5'd8); step();
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        poke_val = 32'hFFFF_FFFD;
        poke = 1'b1;
        step();
        release dut.stall_cnt_q;
        poke = 1'b0;
        chk("sat_loaded", 64'(bus.O_stall_cnt), 64'hFFFF_FFFD);
        offer(1'b1, 1'b1, 64'h99, 5'd9);
        for (int i = 0; i < 5; i++) step();
        chk("sat_value", 64'(bus.O_stall_cnt), 64'hFFFF_FFFF);
        bus.I_flush = 1'b1;
        offer(1'b0, 1'b0, 64'd0, 5'd0);
        step();
        bus.I_flush = 1'b0;
        step();
        chk("sat_after_flush", 64'(bus.O_stall_cnt), 64'hFFFF_FFFF);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_040750_ex_mem_reg.md
Name: ysyx_040750_ex_mem_reg

Overview:
EX/MEM pipeline boundary of the fullpipeline core. Accepts one retired EX operation per handshake: GPR ALU result, PC, store data and control. Presents it to MEM through a valid/ready pair. A 2-entry skid buffer generates the EX-side ready that the ALU uses to decide whether to hold multicycle mul/div results. Also exports a forwarding view of the head entry for ID/EX bypass, plus a stall-cycle counter.

Parameters:
CTRL_W, 16, width of opaque MEM/WB control bundle (mem ren/wen, size, rd wen, etc.); passed through unmodified
RD_W, 5, destination register index width

Ports:
I_sys_clk  in  1  clock; all state updates on rising edge
I_rst  in  1  synchronous active-high reset
I_flush  in  1  kill all buffered entries (trap/redirect)
I_ex_valid  in  1  EX holds a valid instruction
I_ex_result_valid  in  1  ALU O_result_valid (0 while mul/div busy)
I_ex_result  in  64  ALU O_result (address or data)
I_ex_store_data  in  64  rs2 value for stores
I_ex_pc  in  64  instruction PC
I_ex_rd  in  RD_W  destination register
I_ex_rd_wen  in  1  writes GPR
I_ex_ctrl  in  CTRL_W  MEM/WB control bundle
O_ex_ready  out  1  EX→MEM accept; drives ALU I_EX_MEM_ready
O_mem_valid  out  1  head entry valid
I_mem_ready  in  1  MEM consumes head this cycle
O_mem_result  out  64  head result
O_mem_store_data  out  64  head store data
O_mem_pc  out  64  head PC
O_mem_rd  out  RD_W  head rd
O_mem_rd_wen  out  1  head rd write enable
O_mem_ctrl  out  CTRL_W  head control
O_fwd_valid  out  1  O_mem_valid & O_mem_rd_wen & (O_mem_rd != 0)
O_fwd_rd  out  RD_W  = O_mem_rd
O_fwd_data  out  64  = O_mem_result
O_stall_cnt  out  32  cycles with I_ex_valid & I_ex_result_valid & ~O_ex_ready; saturating

Behaviour:
- Storage: head register (H) and skid register (S), each holds the full payload plus a valid bit. Occupancy is EMPTY (H=0,S=0), ONE (H=1,S=0) or TWO (H=1,S=1). S valid implies H valid.
- Accept (acc) = I_ex_valid & I_ex_result_valid & O_ex_ready. An instruction with I_ex_result_valid=0 is never accepted.
- Drain (drn) = O_mem_valid & I_mem_ready.
- O_ex_ready = ~S.valid. It is a pure register output with no combinational path from I_mem_ready. It is 1 out of reset.
- O_mem_* are driven directly from H. There is no combinational path from EX inputs to MEM outputs, so latency is 1 cycle from acceptance to O_mem_valid.
- Transitions (when I_flush=0):
  - EMPTY: acc → H=in, ONE.
  - ONE: acc&drn → H=in, stay ONE. acc&~drn → S=in, TWO. ~acc&drn → EMPTY. Otherwise hold.
  - TWO (acc impossible, ready=0): drn → H=S, S.valid=0, ONE. Otherwise hold.
- Order is preserved: S is never presented before H.
- I_flush=1: next cycle H.valid=S.valid=0 and O_ex_ready=1. Flush overrides a simultaneous acc and drn; the accepted data is discarded. MEM must ignore a drain in the same cycle as a flush. Payload registers need not clear.
- Reset (synchronous, any state, including mid-stall): H.valid=S.valid=0, O_mem_valid=0, O_fwd_valid=0, O_ex_ready=1, O_stall_cnt=0. Payload outputs reset to 0.
- Payload registers load only on the write that selects them; they hold otherwise.
- O_stall_cnt increments by 1 per stall cycle and saturates at 32'hFFFF_FFFF. Flush does not clear it; only reset does.
- Handshake interaction with the ALU: when O_ex_ready=0 during a mul/div completion, the ALU latches its result internally. This block must therefore keep ready low until S drains, and must accept the held result exactly once when ready returns.

Test Plan:
- Reset then idle: I_rst=1 for 2 cycles → O_ex_ready=1, O_mem_valid=0, O_stall_cnt=0. Then one op with result=64'h1234, rd=5, rd_wen=1, mem_ready=1 → next cycle O_mem_valid=1, O_mem_result=64'h1234, O_fwd_valid=1, O_fwd_rd=5.
- Backpressure/skid: mem_ready=0, send A=64'hA then B=64'hB on consecutive cycles → after B, O_ex_ready=0, head=A. Offering C holds it and O_stall_cnt increments each cycle. Raising mem_ready → outputs A, B, C in order, none duplicated or lost.
- Full-throughput: mem_ready=1, 8 back-to-back ops with results 0..7 → O_mem_valid stays 1 for 8 consecutive cycles with results 0..7; O_ex_ready never drops.
- Multicycle: I_ex_valid=1 with I_ex_result_valid=0 for 33 cycles, then 1 with result 64'hFFFF_FFFF_FFFF_FFFE → exactly one entry captured; O_stall_cnt stays 0.
- Flush: in state TWO, assert I_flush together with mem_ready=1 → next cycle O_mem_valid=0 and O_ex_ready=1. The next accepted op 64'h55 appears alone as head.
- rd=0 forwarding and saturation: op with rd=0, rd_wen=1 → O_fwd_valid=0. Force O_stall_cnt to 32'hFFFF_FFFF then stall 3 cycles → value remains 32'hFFFF_FFFF.
